// File: rtl/dff_bank_pkg.sv
// Shared types and constants for the round-robin register bank controller.
package dff_bank_pkg;

  typedef enum logic {ST_IDLE, ST_CLR} state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_NREG  = 8;
  localparam int DEF_WIDTH = 8;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_bank_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first asserted request searched from last+1.
module rr_arbiter
  import dff_bank_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_ctrl.sv
// Shared register bank with round-robin write arbitration and a sequenced clear-all.
module dff_bank_ctrl
  import dff_bank_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int NREG  = DEF_NREG,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int AW    = clog2(NREG)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  input  logic                  clr_all,
  output logic                  busy,
  output logic                  clr_done,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int IW = clog2(NREQ);

  state_t           state;
  logic [AW-1:0]    idx;
  logic [IW-1:0]    last;
  logic [WIDTH-1:0] bank [NREG];

  logic [NREQ-1:0]  eff;
  logic [NREQ-1:0]  win_oh;
  logic [IW-1:0]    win_idx;
  logic             win_vld;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  // The requester acked this cycle is masked so a late deassert cannot write twice.
  assign eff   = req & ~grant;
  assign waddr = req_addr[int'(win_idx)*AW +: AW];
  assign wdata = req_data[int'(win_idx)*WIDTH +: WIDTH];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (eff),
    .last   (last),
    .onehot (win_oh),
    .idx    (win_idx),
    .valid  (win_vld)
  );

  assign rd_data = bank[rd_addr];

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= ST_IDLE;
      idx      <= '0;
      last     <= IW'(NREQ - 1);
      grant    <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      for (int i = 0; i < NREG; i++) bank[i] <= '0;
    end else begin
      grant    <= '0;
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_all) begin
            state <= ST_CLR;
            busy  <= 1'b1;
            idx   <= '0;
          end else if (win_vld) begin
            bank[waddr] <= wdata;
            grant       <= win_oh;
            last        <= win_idx;
          end
        end
        ST_CLR: begin
          bank[idx] <= '0;
          if (idx == AW'(NREG - 1)) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
            idx      <= '0;
            // Grants resume on the final zeroing edge; this write lands after the zero.
            if (win_vld) begin
              bank[waddr] <= wdata;
              grant       <= win_oh;
              last        <= win_idx;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dff_bank_ctrl.md
# dff_bank_ctrl

Controller that shares a bank of NREG flip-flop registers (WIDTH bits each) among NREQ write requesters. Requests are granted round-robin, at most one register write per cycle. A sequenced clear-all walks the bank, zeroing one register per cycle. It sits between the requesting datapath blocks and the register storage, and owns both the storage and the write sequencing.

## Interface

Parameters:
- NREQ, 4, number of write requesters (2..8)
- NREG, 8, number of registers in the bank (power of two, ≥2)
- WIDTH, 8, bits per register
- AW, clog2(NREG), register address width (derived, not overridden)

Ports:
- clock  in  1  single clock; all state updates on posedge clock
- clear  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester write request, level, held until granted
- req_addr  in  NREQ*AW  packed target addresses; requester i uses slice [i*AW +: AW]
- req_data  in  NREQ*WIDTH  packed write data; requester i uses slice [i*WIDTH +: WIDTH]
- grant  out  NREQ  one-hot write acknowledge, one-cycle pulse
- clr_all  in  1  request to zero the whole bank
- busy  out  1  high while the clear-all sequence runs
- clr_done  out  1  one-cycle pulse when clear-all completes
- rd_addr  in  AW  read address
- rd_data  out  WIDTH  combinational read: bank[rd_addr]

## Operation

- States: IDLE and CLR.
- IDLE with clr_all=1: enter CLR. No grant is issued that cycle. clr_all beats any pending req.
- IDLE with clr_all=0 and an effective request pending:
  - Effective request = req & ~grant. The requester acked this cycle is masked, so a late deassert cannot double-write.
  - The round-robin winner is the first effective requester searched from (last+1) mod NREQ.
  - At the edge: bank[winner addr] <= winner data, grant <= onehot(winner), last <= winner.
- CLR: idx starts at 0. Each cycle bank[idx] <= 0 and idx increments.
  - When idx = NREG-1 is written: return to IDLE, pulse clr_done, reset idx to 0.
  - clr_all is ignored while in CLR.
  - req is not granted while in CLR and stays pending.
- Two requesters targeting the same address: only the winner writes that cycle. The loser writes in a later cycle, so the last-granted value persists.
- clear: state=IDLE, idx=0, last=NREQ-1 (requester 0 has first priority), grant=0, busy=0, clr_done=0, all bank registers = 0.
  - Reset mid-CLR or mid-grant aborts immediately; nothing is written that edge.
- rd_data reflects bank contents after the most recent edge. There is no read/write bypass.

## Timing

- Write latency: req sampled at edge N → bank updated and grant high during cycle N+1 → rd_data shows the new value in cycle N+1.
- Requester must drop req (or present the next transaction) in the cycle grant is seen. A held req is re-arbitrated from cycle N+2.
- Throughput: one write per cycle. With all NREQ requesting continuously, each is granted once per NREQ cycles.
- Clear-all: clr_all sampled at edge N → busy=1 from cycle N+1.
  - bank[k] is zero after edge N+1+k.
  - busy falls and clr_done pulses in cycle N+1+NREG (after NREG zeroing edges). Grants resume from that cycle's edge.
- Output reset values: grant=0, busy=0, clr_done=0, rd_data=0.

## Structure

- Shared package dff_bank_pkg holds:
  - state enum {ST_IDLE, ST_CLR}
  - a clog2 helper for AW
  - default parameter constants
- Sub-module rr_arbiter (NREQ, combinational): inputs are the request vector and the last-winner index; outputs are the one-hot winner, winner index and valid.
- The bank, FSM, idx counter and last register live in the top level.

## Test plan

- Reset, then req=4'b0001, addr0=3, data0=8'hA5 → grant=4'b0001 in the next cycle; rd_addr=3 gives 8'hA5; all other registers read 0.
- req=4'b1111 held for 8 cycles, distinct addr/data per requester → grants 0,1,2,3,0,1,2,3 with no gap cycles; each register holds its requester's data.
- req0 and req2 both target addr 5 with data 8'h11 and 8'h22, requests dropped on grant → req0 granted first, then req2; final bank[5]=8'h22.
- Load all 8 registers with 8'hFF, pulse clr_all with req1 pending:
  - busy high for exactly 8 cycles; bank[k] reads 0 in sequence; no grant during busy.
  - clr_done pulses once; req1 is granted in the cycle clr_done is high.
- Assert clear on the 3rd cycle of CLR → next cycle busy=0, grant=0, all registers 0; the next req is granted starting from requester 0.
- Hold req=4'b0010 without dropping → grant pulses every other cycle. The same data is written each time, and no back-to-back grant goes to the same requester.
